// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmitter.
//   WordWidth   : bits per transmitted word
//   QuiesceBits : number of '1' bits sent at the start of every frame
//   tx_state_e  : transmitter FSM states
//   word_parity : parity bit that makes sync + data + parity even
package coax_pkg;

    localparam int unsigned WordWidth   = 10;
    localparam int unsigned QuiesceBits = 5;

    typedef enum logic [2:0] {
        StIdle,
        StQuiesce,
        StStartCv,
        StSync,
        StData,
        StParity,
        StEndBit,
        StEndCv
    } tx_state_e;

    // The sync bit is always '1', so the parity bit is the XNOR of the data.
    function automatic logic word_parity(input logic [WordWidth-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Half-cell timer for the coax transmitter.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   start_i     restart timing at the first clock of a frame
//   en_i        timer runs while high; held at zero otherwise
//   half_end_o  last clock of a half-cell
//   cell_end_o  last clock of a full bit cell (second half-cell)
module coax_tx_bit_timer #(
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic en_i,
    output logic half_end_o,
    output logic cell_end_o
);

    localparam int unsigned HalfClocks = CLOCKS_PER_BIT / 2;
    localparam int unsigned CntW       = (HalfClocks > 1) ? $clog2(HalfClocks) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HalfClocks - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    assign half_end_o = en_i && (cnt_q == CntMax);
    // Phase is 1 during the second half of a cell.
    assign cell_end_o = half_end_o && phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (start_i || !en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end_o) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/coax_tx.sv
// Coax word transmitter: frames 10-bit words as
//   QUIESCE (5 x '1') | START_CV | { SYNC '1' | 10 data bits MSB first | parity } x N
//   | END_BIT '0' | END_CV
// Bits are biphase coded: '1' = high then low, '0' = low then high.
// Optional feature: define COAX_TX_PARITY_INJECT_EN to add inject_parity, which inverts
// the parity bit of the word loaded while it is high.
// Ports:
//   clk            clock (rising edge)
//   reset          synchronous active-low reset
//   data           word to transmit
//   valid          data offered; taken when valid && ready
//   inject_parity  (COAX_TX_PARITY_INJECT_EN only) corrupt parity of next loaded word
//   ready          holding register empty
//   tx             registered line drive, 0 when idle
//   active         frame in progress
// CLOCKS_PER_BIT must be even and at least 4.
module coax_tx
    import coax_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WordWidth-1:0] data,
    input  logic                 valid,
`ifdef COAX_TX_PARITY_INJECT_EN
    input  logic                 inject_parity,
`endif
    output logic                 ready,
    output logic                 tx,
    output logic                 active
);

    localparam int unsigned HcW = 5;
    // Index of the last half-cell of each segment.
    localparam logic [HcW-1:0] HcQuiesceLast     = HcW'(2 * QuiesceBits - 1);
    localparam logic [HcW-1:0] HcStartCvLast     = HcW'(5);
    localparam logic [HcW-1:0] HcDataLast        = HcW'(2 * WordWidth - 1);
    localparam logic [HcW-1:0] HcEndCvLast       = HcW'(2);
    localparam logic [HcW-1:0] HcBitLast         = HcW'(1);
    localparam logic [HcW-1:0] StartCvHighHalves = HcW'(3);

    tx_state_e            state_q, state_d;
    logic [HcW-1:0]       hc_q, hc_d, last_half;
    logic [WordWidth-1:0] hold_q, hold_d, shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 half_end, cell_end, seg_done;
    logic                 accept, load, frame_start, inject, cell_bit;

`ifdef COAX_TX_PARITY_INJECT_EN
    assign inject = inject_parity;
`else
    assign inject = 1'b0;
`endif

    assign ready  = ~hold_full_q;
    assign active = (state_q != StIdle);
    assign tx     = tx_q;
    assign accept = valid && !hold_full_q;

    coax_tx_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .start_i   (frame_start),
        .en_i      (active),
        .half_end_o(half_end),
        .cell_end_o(cell_end)
    );

    always_comb begin
        case (state_q)
            StQuiesce: last_half = HcQuiesceLast;
            StStartCv: last_half = HcStartCvLast;
            StData:    last_half = HcDataLast;
            StEndCv:   last_half = HcEndCvLast;
            default:   last_half = HcBitLast;
        endcase
    end

    assign seg_done = half_end && (hc_q == last_half);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (hold_full_q) state_d = StQuiesce;
            StQuiesce: if (seg_done) state_d = StStartCv;
            StStartCv: if (seg_done) state_d = StSync;
            StSync:    if (seg_done) state_d = StData;
            StData:    if (seg_done) state_d = StParity;
            StParity:  if (seg_done) state_d = hold_full_q ? StSync : StEndBit;
            StEndBit:  if (seg_done) state_d = StEndCv;
            // A word arriving on the final END_CV edge still chains straight into a new frame.
            StEndCv:   if (seg_done) state_d = (hold_full_q || accept) ? StQuiesce : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign frame_start = (state_d == StQuiesce) && (state_q != StQuiesce);
    assign load        = (state_d == StSync) && (state_q != StSync);

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hc_d        = hc_q;

        if (state_d != state_q) begin
            hc_d = '0;
        end else if (half_end) begin
            hc_d = hc_q + HcW'(1);
        end

        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        // Load only happens with the holding register full, so it never collides with accept.
        if (load) begin
            shift_d     = hold_q;
            par_d       = word_parity(hold_q) ^ inject;
            hold_full_d = 1'b0;
        end else if ((state_q == StData) && cell_end) begin
            shift_d = {shift_q[WordWidth-2:0], 1'b0};
        end
    end

    // tx is computed from next-state values so the registered line lines up with state_q.
    always_comb begin
        case (state_d)
            StQuiesce, StSync: cell_bit = 1'b1;
            StData:            cell_bit = shift_d[WordWidth-1];
            StParity:          cell_bit = par_d;
            default:           cell_bit = 1'b0;
        endcase
        case (state_d)
            StIdle:    tx_d = 1'b0;
            StStartCv: tx_d = (hc_d < StartCvHighHalves);
            StEndCv:   tx_d = 1'b1;
            default:   tx_d = cell_bit ^ hc_d[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            hc_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_coax_tx.sv
// Self-checking bench for coax_tx (CLOCKS_PER_BIT = 8).
module tb_coax_tx;

    localparam int CPB = 8;
    localparam int H   = CPB / 2;

    logic       clk;
    logic       reset;
    logic [9:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       active;
`ifdef COAX_TX_PARITY_INJECT_EN
    logic       inject_parity;
`endif

    coax_tx #(
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .valid        (valid),
`ifdef COAX_TX_PARITY_INJECT_EN
        .inject_parity(inject_parity),
`endif
        .ready        (ready),
        .tx           (tx),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per continuous active period. nf[k] marks a word that opens a new frame.
    typedef struct packed {
        int               n;
        logic [3:0][9:0]  w;
        logic [3:0]       p;
        logic [3:0]       nf;
        logic             aborted;
        int               abort_len;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   pushed   = 0;
    int   done_cnt = 0;
    logic cap[$];
    logic ref_q[$];
    int   woff[4];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void add_run(input logic v, input int len);
        for (int i = 0; i < len; i++) ref_q.push_back(v);
    endfunction

    function automatic void add_bit(input logic b);
        add_run(b, H);
        add_run(~b, H);
    endfunction

    function automatic void add_end();
        add_bit(1'b0);
        add_run(1'b1, 3 * H);
    endfunction

    function automatic void build(input exp_t e);
        ref_q.delete();
        for (int k = 0; k < e.n; k++) begin
            if (k == 0 || e.nf[k]) begin
                if (k > 0) add_end();
                for (int i = 0; i < 5; i++) add_bit(1'b1);
                add_run(1'b1, 3 * H);
                add_run(1'b0, 3 * H);
            end
            woff[k] = ref_q.size();
            add_bit(1'b1);
            for (int i = 9; i >= 0; i--) add_bit(e.w[k][i]);
            add_bit(e.p[k]);
        end
        add_end();
    endfunction

    function automatic int run_len(input int s, input logic v);
        int r = 0;
        while ((s + r) < cap.size() && cap[s+r] === v) r++;
        return r;
    endfunction

    function automatic void check_frame(input exp_t e);
        int   first_bad;
        logic [9:0] d;
        if (e.aborted) begin
            check("abort_len", 32'(cap.size()), 32'(e.abort_len));
            return;
        end
        build(e);
        check("frame_len", 32'(cap.size()), 32'(ref_q.size()));
        if (cap.size() != ref_q.size()) return;
        first_bad = -1;
        for (int i = 0; i < ref_q.size(); i++)
            if (first_bad < 0 && cap[i] !== ref_q[i]) first_bad = i;
        check("wave_mismatch_at", 32'(first_bad), 32'hFFFF_FFFF);
        check("startcv_high", 32'(run_len(5 * CPB, 1'b1)), 32'(3 * H));
        check("startcv_low", 32'(run_len(5 * CPB + 3 * H, 1'b0)), 32'(3 * H));
        check("sync_first_half", 32'(run_len(8 * CPB, 1'b1)), 32'(H));
        for (int k = 0; k < e.n; k++) begin
            for (int j = 0; j < 10; j++) d[9-j] = cap[woff[k] + CPB * (1 + j) + 1];
            check($sformatf("data_w%0d", k), 32'(d), 32'(e.w[k]));
            check($sformatf("parity_w%0d", k), 32'(cap[woff[k] + 11 * CPB + 1]), 32'(e.p[k]));
        end
    endfunction

    // Monitor: capture tx for each active period, then score it against the next expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (active === 1'b1) begin
                cap.delete();
                while (active === 1'b1 && cap.size() < 3000) begin
                    cap.push_back(tx);
                    @(negedge clk);
                end
                check("idle_tx_after_frame", 32'(tx), 32'(0));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got frame of %0d clocks, required none",
                             cap.size());
                end else begin
                    e = exp_q.pop_front();
                    check_frame(e);
                end
                done_cnt++;
            end
        end
    end

    task automatic push_exp(input exp_t e);
        exp_q.push_back(e);
        pushed++;
    endtask

    // Returns on the clock after the handshake edge, i.e. one clock before the frame's
    // first active cycle when starting from idle.
    task automatic send(input logic [9:0] w);
        int n = 0;
        data  = w;
        valid = 1'b1;
        while (!ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready=%0b required 1", ready);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((done_cnt != pushed || active !== 1'b0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL idle_wait: frames scored %0d required %0d", done_cnt, pushed);
        end
        step(3);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: bench still running, required completion");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        reset = 1'b0;
        valid = 1'b0;
        data  = '0;
`ifdef COAX_TX_PARITY_INJECT_EN
        inject_parity = 1'b0;
`endif
        step(3);
        check("reset_tx", 32'(tx), 32'(0));
        check("reset_active", 32'(active), 32'(0));
        check("reset_ready", 32'(ready), 32'(1));
        reset = 1'b1;
        step(2);

        // Single word 2AA: five ones -> parity 0; 180 clocks.
        e = '0; e.n = 1; e.w[0] = 10'h2AA; e.p[0] = 1'b0;
        push_exp(e);
        send(10'h2AA);
        wait_idle();

        // 3FF (ten ones -> parity 1) then 001 (one one -> parity 0), second offered in DATA.
        e = '0; e.n = 2; e.w[0] = 10'h3FF; e.p[0] = 1'b1; e.w[1] = 10'h001; e.p[1] = 1'b0;
        push_exp(e);
        send(10'h3FF);
        step(80);
        send(10'h001);
        wait_idle();

        // Four words with valid held high: 123 (4 ones), 0F0 (4), 3C4 (5), 155 (5).
        e = '0; e.n = 4;
        e.w[0] = 10'h123; e.p[0] = 1'b1;
        e.w[1] = 10'h0F0; e.p[1] = 1'b1;
        e.w[2] = 10'h3C4; e.p[2] = 1'b0;
        e.w[3] = 10'h155; e.p[3] = 1'b0;
        push_exp(e);
        send(10'h123);
        check("ready_low_when_held", 32'(ready), 32'(0));
        send(10'h0F0);
        send(10'h3C4);
        send(10'h155);
        wait_idle();

        // Words accepted in END_BIT (frame cycle 164) and END_CV (cycle 350) chain frames.
        e = '0; e.n = 3; e.nf = 4'b0110;
        e.w[0] = 10'h0F0; e.p[0] = 1'b1;
        e.w[1] = 10'h2AA; e.p[1] = 1'b0;
        e.w[2] = 10'h3FF; e.p[2] = 1'b1;
        push_exp(e);
        send(10'h0F0);
        step(165);
        send(10'h2AA);
        step(185);
        send(10'h3FF);
        wait_idle();

        // Reset in the 4th DATA bit of 2AA with 0F0 waiting in the holding register.
        e = '0; e.aborted = 1'b1; e.abort_len = 100;
        push_exp(e);
        send(10'h2AA);
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (c == 63) check("ready_before_sync", 32'(ready), 32'(0));
            if (c == 64) check("ready_at_sync", 32'(ready), 32'(1));
            if (c == 70) begin
                data  = 10'h0F0;
                valid = 1'b1;
            end
            if (c == 71) valid = 1'b0;
            if (c == 72) check("ready_low_second", 32'(ready), 32'(0));
            if (c == 99) reset = 1'b0;
        end
        step(1);
        check("abort_tx", 32'(tx), 32'(0));
        check("abort_active", 32'(active), 32'(0));
        check("abort_ready", 32'(ready), 32'(1));
        reset = 1'b1;
        wait_idle();

        e = '0; e.n = 1; e.w[0] = 10'h001; e.p[0] = 1'b0;
        push_exp(e);
        send(10'h001);
        wait_idle();

`ifdef COAX_TX_PARITY_INJECT_EN
        // 000 normally has parity 1; injected on the first word only.
        e = '0; e.n = 2; e.w[0] = 10'h000; e.p[0] = 1'b0; e.w[1] = 10'h000; e.p[1] = 1'b1;
        push_exp(e);
        inject_parity = 1'b1;
        send(10'h000);
        step(80);
        inject_parity = 1'b0;
        send(10'h000);
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
